// File: rtl/dither_pkg.sv
// Shared constants, pixel struct and loader state encoding for the dithering datapath.
package dither_pkg;

  localparam int IMAGEX   = 64;
  localparam int IMAGEY   = 64;
  localparam int RGB_SIZE = 8;
  localparam int NPIX     = IMAGEX * IMAGEY;
  localparam int ADDR_W   = $clog2(NPIX);

  typedef struct packed {
    logic [RGB_SIZE-1:0] r;
    logic [RGB_SIZE-1:0] g;
    logic [RGB_SIZE-1:0] b;
  } rgb_t;

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } ingest_state_e;

endpackage

// File: rtl/rgb_to_luma.sv
// Combinational luma: (77*r + 150*g + 29*b) >> 8 using a 16-bit intermediate.
module rgb_to_luma
  import dither_pkg::*;
(
  input  logic [RGB_SIZE-1:0] i_red,
  input  logic [RGB_SIZE-1:0] i_green,
  input  logic [RGB_SIZE-1:0] i_blue,
  output logic [RGB_SIZE-1:0] o_luma
);

  // Weights sum to 256, so the worst case 256*255 still fits in 16 bits.
  function automatic logic [RGB_SIZE-1:0] weighted_luma(
    input logic [RGB_SIZE-1:0] r,
    input logic [RGB_SIZE-1:0] g,
    input logic [RGB_SIZE-1:0] b
  );
    logic [15:0] sum;
    sum = 16'd77 * 16'(r) + 16'd150 * 16'(g) + 16'd29 * 16'(b);
    return sum[15:8];
  endfunction

  assign o_luma = weighted_luma(i_red, i_green, i_blue);

endmodule

// File: rtl/pixel_ingest_loader.sv
// Raster pixel ingest into the frame buffer write port, with frame handoff and in_last checking.
// Optional GRAYSCALE_EN: writes luma on all three channels instead of the raw RGB.
module pixel_ingest_loader
  import dither_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [RGB_SIZE-1:0] in_red,
  input  logic [RGB_SIZE-1:0] in_green,
  input  logic [RGB_SIZE-1:0] in_blue,
  input  logic                in_last,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [RGB_SIZE-1:0] wr_red,
  output logic [RGB_SIZE-1:0] wr_green,
  output logic [RGB_SIZE-1:0] wr_blue,
  output logic                frame_ready,
  input  logic                frame_ack,
  output logic                frame_err,
  output logic [15:0]         frame_count
);

  ingest_state_e     r_state;
  ingest_state_e     w_state_nxt;
  logic [ADDR_W-1:0] r_pix_cnt;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  rgb_t              r_wr_pix;
  logic              r_frame_err;
  logic [15:0]       r_frame_count;

  logic              w_accept;
  logic              w_last_pix;
  rgb_t              w_pix;

  assign in_ready   = (r_state == LOAD);
  assign w_accept   = in_valid && in_ready;
  assign w_last_pix = (r_pix_cnt == ADDR_W'(NPIX - 1));

`ifdef GRAYSCALE_EN
  logic [RGB_SIZE-1:0] w_luma;

  rgb_to_luma u_rgb_to_luma (
    .i_red   (in_red),
    .i_green (in_green),
    .i_blue  (in_blue),
    .o_luma  (w_luma)
  );

  assign w_pix = '{r: w_luma, g: w_luma, b: w_luma};
`else
  assign w_pix = '{r: in_red, g: in_green, b: in_blue};
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LOAD:    if (w_accept && w_last_pix) w_state_nxt = FULL;
      FULL:    if (frame_ack)              w_state_nxt = LOAD;
      default: w_state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= LOAD;
    else     r_state <= w_state_nxt;
  end

  // Write stage: accepted beat appears on the write port one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pix_cnt     <= '0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_pix      <= '0;
      r_frame_err   <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_wr_en     <= w_accept;
      r_frame_err <= w_accept && (in_last != w_last_pix);
      if (w_accept) begin
        r_wr_addr <= r_pix_cnt;
        r_wr_pix  <= w_pix;
        // An early in_last drops the partial frame; the next beat restarts at 0.
        if (w_last_pix || in_last) r_pix_cnt <= '0;
        else                       r_pix_cnt <= r_pix_cnt + 1'b1;
        if (w_last_pix) r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_red      = r_wr_pix.r;
  assign wr_green    = r_wr_pix.g;
  assign wr_blue     = r_wr_pix.b;
  assign frame_err   = r_frame_err;
  assign frame_count = r_frame_count;
  assign frame_ready = (r_state == FULL);

endmodule
